// File: rtl/matrix_alu_processor.sv
// Lane-parallel elementwise add/sub over two captured matrices.
// Wrap or saturate arithmetic with a sticky overflow flag.
module matrix_alu_processor #(
  parameter int MATRIX_ROWS = 4,
  parameter int MATRIX_COLS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int LANE_COUNT  = 2
) (
  input  logic clock_signal,
  input  logic reset_signal,
  input  logic start_operation,
  input  logic [1:0] op_mode,
  input  logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0][DATA_WIDTH-1:0] matrix_a_input,
  input  logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0][DATA_WIDTH-1:0] matrix_b_input,
  output logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0][DATA_WIDTH-1:0] matrix_result_output,
  output logic operation_busy,
  output logic operation_complete,
  output logic overflow_flag
);

  localparam int TOTAL = MATRIX_ROWS * MATRIX_COLS;
  localparam int BEATS = TOTAL / LANE_COUNT;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  if (TOTAL % LANE_COUNT != 0) begin : g_lane_check
    $error("MATRIX_ROWS*MATRIX_COLS must be divisible by LANE_COUNT");
  end

  typedef logic [TOTAL-1:0][DATA_WIDTH-1:0] flat_t;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t state_q;
  logic [BW-1:0] beat_q;
  logic [1:0] mode_q;
  flat_t a_q;
  flat_t b_q;
  flat_t res_q;
  logic busy_q;
  logic done_q;
  logic ovf_q;

  logic [IW-1:0] lane_idx [LANE_COUNT];
  logic [DATA_WIDTH:0] lane_sum [LANE_COUNT];
  logic [DATA_WIDTH:0] lane_dif [LANE_COUNT];
  logic [DATA_WIDTH-1:0] lane_res [LANE_COUNT];
  logic lane_ov [LANE_COUNT];
  logic any_ov;

  // Per-lane element arithmetic for the current beat
  always_comb begin
    any_ov = 1'b0;
    for (int l = 0; l < LANE_COUNT; l++) begin
      lane_idx[l] = IW'(int'(beat_q) * LANE_COUNT + l);
      lane_sum[l] = {1'b0, a_q[lane_idx[l]]} + {1'b0, b_q[lane_idx[l]]};
      lane_dif[l] = {1'b0, a_q[lane_idx[l]]} - {1'b0, b_q[lane_idx[l]]};
      lane_res[l] = '0;
      lane_ov[l] = 1'b0;
      unique case (1'b1)
        (mode_q == 2'b00): begin
          lane_res[l] = lane_sum[l][DATA_WIDTH-1:0];
          lane_ov[l] = lane_sum[l][DATA_WIDTH];
        end
        (mode_q == 2'b01): begin
          lane_res[l] = lane_dif[l][DATA_WIDTH-1:0];
          lane_ov[l] = lane_dif[l][DATA_WIDTH];
        end
        (mode_q == 2'b10): begin
          lane_res[l] = lane_sum[l][DATA_WIDTH] ? '1
                      : lane_sum[l][DATA_WIDTH-1:0];
          lane_ov[l] = lane_sum[l][DATA_WIDTH];
        end
        default: begin
          lane_res[l] = lane_dif[l][DATA_WIDTH] ? '0
                      : lane_dif[l][DATA_WIDTH-1:0];
          lane_ov[l] = lane_dif[l][DATA_WIDTH];
        end
      endcase
      any_ov = any_ov | lane_ov[l];
    end
  end

  // Control FSM, operand capture and result accumulation
  always_ff @(posedge clock_signal or negedge reset_signal) begin
    if (!reset_signal) begin
      state_q <= IDLE;
      beat_q <= '0;
      mode_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_operation) begin
            a_q <= matrix_a_input;
            b_q <= matrix_b_input;
            mode_q <= op_mode;
            res_q <= '0;
            ovf_q <= 1'b0;
            beat_q <= '0;
            busy_q <= 1'b1;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int l = 0; l < LANE_COUNT; l++) begin
            res_q[lane_idx[l]] <= lane_res[l];
          end
          if (any_ov) ovf_q <= 1'b1;
          beat_q <= beat_q + 1'b1;
          if (beat_q == LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign matrix_result_output = res_q;
  assign operation_busy = busy_q;
  assign operation_complete = done_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_matrix_alu_processor.sv
// Bench for matrix_alu_processor: vector table, scoreboard,
// lane-count builds, restart-ignore and mid-op reset sequences.
module tb_matrix_alu_processor;

  typedef logic [3:0][3:0][7:0] mat_t;
  typedef struct {
    mat_t res;
    logic ov;
  } exp_t;
  typedef struct {
    string nm;
    logic [1:0] md;
    logic [7:0] av;
    logic [7:0] bv;
    logic ramp;
    logic [7:0] ev;
    logic eo;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start;
  logic [1:0] mode;
  mat_t a, b;
  mat_t res, res1, res16;
  logic busy, comp, ov;
  logic busy1, comp1, ov1;
  logic busy16, comp16, ov16;

  int n_total = 0;
  int n_pass = 0;
  exp_t sb[$];

  matrix_alu_processor dut (
    .clock_signal(clk), .reset_signal(rst_n),
    .start_operation(start), .op_mode(mode),
    .matrix_a_input(a), .matrix_b_input(b),
    .matrix_result_output(res), .operation_busy(busy),
    .operation_complete(comp), .overflow_flag(ov)
  );

  matrix_alu_processor #(.LANE_COUNT(1)) dut1 (
    .clock_signal(clk), .reset_signal(rst_n),
    .start_operation(start), .op_mode(mode),
    .matrix_a_input(a), .matrix_b_input(b),
    .matrix_result_output(res1), .operation_busy(busy1),
    .operation_complete(comp1), .overflow_flag(ov1)
  );

  matrix_alu_processor #(.LANE_COUNT(16)) dut16 (
    .clock_signal(clk), .reset_signal(rst_n),
    .start_operation(start), .op_mode(mode),
    .matrix_a_input(a), .matrix_b_input(b),
    .matrix_result_output(res16), .operation_busy(busy16),
    .operation_complete(comp16), .overflow_flag(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  function automatic mat_t ramp_a();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = 8'(r * 4 + c + 1);
    return m;
  endfunction

  function automatic mat_t ramp_b();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = 8'((r + c) * 2);
    return m;
  endfunction

  function automatic mat_t ramp_sum();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = 8'(6 * r + 3 * c + 1);
    return m;
  endfunction

  function automatic mat_t fill(input logic [7:0] v);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = v;
    return m;
  endfunction

  task automatic do_op(input string nm, input logic [1:0] md,
                       input mat_t ma, input mat_t mb,
                       input mat_t er, input logic eo);
    int edges;
    int busy_cnt;
    bit done;
    exp_t got;
    @(negedge clk);
    start = 1'b1;
    mode = md;
    a = ma;
    b = mb;
    sb.push_back('{er, eo});
    edges = 0;
    busy_cnt = 0;
    done = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (comp) done = 1'b1;
    end
    check({nm, " done"}, 128'(done), 128'(1));
    check({nm, " latency"}, 128'(edges), 128'(9));
    check({nm, " busy"}, 128'(busy_cnt), 128'(8));
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check({nm, " result"}, res, got.res);
      check({nm, " ovf"}, 128'(ov), 128'(got.ov));
    end
  endtask

  initial begin
    vec_t vt[9];
    int e1, e2, e16, pulses, bad;

    vt = '{
      '{"add_wrap_ramp", 2'b00, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0},
      '{"add_sat_200", 2'b10, 8'd200, 8'd100, 1'b0, 8'd255, 1'b1},
      '{"add_wrap_200", 2'b00, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1},
      '{"sub_sat_5_9", 2'b11, 8'd5, 8'd9, 1'b0, 8'd0, 1'b1},
      '{"sub_wrap_5_9", 2'b01, 8'd5, 8'd9, 1'b0, 8'd252, 1'b1},
      '{"sub_wrap_9_5", 2'b01, 8'd9, 8'd5, 1'b0, 8'd4, 1'b0},
      '{"sub_sat_9_5", 2'b11, 8'd9, 8'd5, 1'b0, 8'd4, 1'b0},
      '{"add_wrap_255_1", 2'b00, 8'd255, 8'd1, 1'b0, 8'd0, 1'b1},
      '{"add_sat_10_20", 2'b10, 8'd10, 8'd20, 1'b0, 8'd30, 1'b0}
    };

    rst_n = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    a = fill(8'd0);
    b = fill(8'd0);

    #3;
    check("reset res", res, 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset comp", 128'(comp), 128'(0));
    check("reset ovf", 128'(ov), 128'(0));

    start = 1'b1;
    a = fill(8'd7);
    b = fill(8'd7);
    @(negedge clk);
    check("start during reset", 128'(busy), 128'(0));
    start = 1'b0;
    rst_n = 1'b1;

    e1 = 0;
    e2 = 0;
    e16 = 0;
    @(negedge clk);
    start = 1'b1;
    mode = 2'b00;
    a = ramp_a();
    b = ramp_b();
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (comp && e2 == 0) e2 = k;
      if (comp1 && e1 == 0) e1 = k;
      if (comp16 && e16 == 0) e16 = k;
    end
    check("lane2 latency", 128'(e2), 128'(9));
    check("lane1 latency", 128'(e1), 128'(17));
    check("lane16 latency", 128'(e16), 128'(2));
    check("lane2 result", res, ramp_sum());
    check("lane1 result", res1, ramp_sum());
    check("lane16 result", res16, ramp_sum());
    check("lane1 ovf", 128'(ov1), 128'(0));
    check("lane16 ovf", 128'(ov16), 128'(0));

    for (int i = 0; i < 9; i++) begin
      if (vt[i].ramp)
        do_op(vt[i].nm, vt[i].md, ramp_a(), ramp_b(),
              ramp_sum(), vt[i].eo);
      else
        do_op(vt[i].nm, vt[i].md, fill(vt[i].av), fill(vt[i].bv),
              fill(vt[i].ev), vt[i].eo);
      if (vt[i].ramp) begin
        check("ramp [0][0]", 128'(res[0][0]), 128'(1));
        check("ramp [3][3]", 128'(res[3][3]), 128'(28));
      end
    end

    @(negedge clk);
    start = 1'b1;
    mode = 2'b00;
    a = ramp_a();
    b = ramp_b();
    @(posedge clk);
    @(negedge clk);
    check("cleared on accept", 128'(res[0][0]), 128'(0));
    a = fill(8'd255);
    b = fill(8'd255);
    mode = 2'b11;
    pulses = 0;
    for (int k = 2; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) begin
        check("beat0 written", 128'(res[0][1]), 128'(4));
        check("unwritten zero", 128'(res[3][3]), 128'(0));
      end
      if (k == 5) start = 1'b0;
      if (comp) pulses++;
    end
    check("restart pulses", 128'(pulses), 128'(1));
    check("restart result", res, ramp_sum());
    check("restart ovf", 128'(ov), 128'(0));

    @(negedge clk);
    start = 1'b1;
    mode = 2'b01;
    a = fill(8'd5);
    b = fill(8'd9);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("pre-reset ovf", 128'(ov), 128'(1));
    check("pre-reset part", 128'(res[1][1]), 128'(252));
    #2;
    rst_n = 1'b0;
    #1;
    check("midop reset res", res, 128'(0));
    check("midop reset busy", 128'(busy), 128'(0));
    check("midop reset comp", 128'(comp), 128'(0));
    check("midop reset ovf", 128'(ov), 128'(0));
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (comp || busy) bad++;
    end
    check("no stale complete", 128'(bad), 128'(0));
    do_op("post_reset_ramp", 2'b00, ramp_a(), ramp_b(),
          ramp_sum(), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
